// File: rtl/rob_dispatch_receiver.sv
// Circular reorder buffer at the receiving end of the Decode->ROB pipeline register.
// Allocates one decoded instruction per cycle, marks entries done on writeback and
// retires them in program order to the commit stage.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      synchronous squash of all entries (overflow_err kept)
//   RType/IType/SType_valid_ROB, imm_ROB, executionID_ROB
//                              instruction from the pipeline register
//   ROB_ready                  room for more; upstream halt = ~ROB_ready
//   alloc_valid, alloc_tag     allocation this cycle and its tag
//   wb_valid, wb_tag, wb_data  execution writeback
//   commit_ready               commit stage can take the head entry
//   commit_*                   head entry, zero when commit_valid is low
//   overflow_err               sticky: instruction arrived while full
module rob_dispatch_receiver #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 7,
    parameter int unsigned EXEC_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  RType_valid_ROB,
    input  logic                  IType_valid_ROB,
    input  logic                  SType_valid_ROB,
    input  logic [DATA_WIDTH-1:0] imm_ROB,
    input  logic [EXEC_WIDTH-1:0] executionID_ROB,
    output logic                  ROB_ready,
    output logic                  alloc_valid,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  wb_valid,
    input  logic [TAG_WIDTH-1:0]  wb_tag,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  commit_ready,
    output logic                  commit_valid,
    output logic [TAG_WIDTH-1:0]  commit_tag,
    output logic [2:0]            commit_type,
    output logic [DATA_WIDTH-1:0] commit_imm,
    output logic [EXEC_WIDTH-1:0] commit_executionID,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic                  overflow_err
);

    localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] CntFull     = (TAG_WIDTH + 1)'(DEPTH);
    // One slot of slack for the instruction already sitting in the pipeline register.
    localparam logic [TAG_WIDTH:0] CntReadyMax = (TAG_WIDTH + 1)'(DEPTH - 2);

    logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_WIDTH:0]   count_q, count_d;
    logic [DEPTH-1:0]     busy_q, busy_d, done_q, done_d;
    logic                 accept_en_q, accept_en_d;
    logic                 overflow_q, overflow_d;

    logic [2:0]            type_q [DEPTH];
    logic [DATA_WIDTH-1:0] imm_q  [DEPTH];
    logic [EXEC_WIDTH-1:0] exec_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic any_valid, full, alloc, wb_fire, commit_fire;

    assign any_valid = RType_valid_ROB | IType_valid_ROB | SType_valid_ROB;
    assign full      = (count_q == CntFull);
    // accept_en low means the pipeline register was halted and still holds an
    // instruction that has already been allocated.
    assign alloc     = any_valid & accept_en_q & ~full;
    // A writeback aimed at the slot being allocated right now loses to the allocation.
    assign wb_fire   = wb_valid & busy_q[wb_tag] & ~(alloc & (wb_tag == tail_q));

    assign ROB_ready    = (count_q <= CntReadyMax);
    assign commit_valid = busy_q[head_q] & done_q[head_q];
    assign commit_fire  = commit_valid & commit_ready;
    assign overflow_err = overflow_q;

    always_comb begin
        alloc_valid        = alloc;
        alloc_tag          = alloc ? tail_q : '0;
        commit_tag         = '0;
        commit_type        = '0;
        commit_imm         = '0;
        commit_executionID = '0;
        commit_data        = '0;
        if (commit_valid) begin
            commit_tag         = head_q;
            commit_type        = type_q[head_q];
            commit_imm         = imm_q[head_q];
            commit_executionID = exec_q[head_q];
            commit_data        = data_q[head_q];
        end
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = done_q;
        accept_en_d = ROB_ready;
        overflow_d  = overflow_q | (any_valid & accept_en_q & full);

        if (wb_fire) begin
            done_d[wb_tag] = 1'b1;
        end
        if (alloc) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + 1'b1;
        end
        if (commit_fire) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
        end
        if (alloc && !commit_fire) begin
            count_d = count_q + 1'b1;
        end else if (!alloc && commit_fire) begin
            count_d = count_q - 1'b1;
        end

        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            busy_d      = '0;
            done_d      = '0;
            accept_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            busy_q      <= '0;
            done_q      <= '0;
            accept_en_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            accept_en_q <= accept_en_d;
            overflow_q  <= overflow_d;
        end
    end

    // Payload storage needs no reset: it is only visible while busy/done are set.
    always_ff @(posedge clk) begin
        if (alloc) begin
            type_q[tail_q] <= {SType_valid_ROB, IType_valid_ROB, RType_valid_ROB};
            imm_q[tail_q]  <= imm_ROB;
            exec_q[tail_q] <= executionID_ROB;
        end
        if (wb_fire) begin
            data_q[wb_tag] <= wb_data;
        end
    end

endmodule

// File: tb/tb_rob_dispatch_receiver.sv
// Directed self-checking bench for rob_dispatch_receiver with an 8-entry buffer.
module tb_rob_dispatch_receiver;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        r_v, i_v, s_v;
    logic [31:0] imm;
    logic [3:0]  exec_id;
    logic        rob_ready, alloc_valid;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic        commit_ready, commit_valid;
    logic [2:0]  commit_tag, commit_type;
    logic [31:0] commit_imm, commit_data;
    logic [3:0]  commit_exec;
    logic        overflow_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rob_dispatch_receiver #(
        .DATA_WIDTH(32),
        .TAG_WIDTH (3),
        .EXEC_WIDTH(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .RType_valid_ROB   (r_v),
        .IType_valid_ROB   (i_v),
        .SType_valid_ROB   (s_v),
        .imm_ROB           (imm),
        .executionID_ROB   (exec_id),
        .ROB_ready         (rob_ready),
        .alloc_valid       (alloc_valid),
        .alloc_tag         (alloc_tag),
        .wb_valid          (wb_valid),
        .wb_tag            (wb_tag),
        .wb_data           (wb_data),
        .commit_ready      (commit_ready),
        .commit_valid      (commit_valid),
        .commit_tag        (commit_tag),
        .commit_type       (commit_type),
        .commit_imm        (commit_imm),
        .commit_executionID(commit_exec),
        .commit_data       (commit_data),
        .overflow_err      (overflow_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt_m;
        bit  acc_m, exp_alloc, exp_rdy;
        int  imm_n;

        rst = 1'b1; flush = 1'b0; r_v = 1'b0; i_v = 1'b0; s_v = 1'b0;
        imm = '0; exec_id = '0; wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
        commit_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(rob_ready), 32'd1);
        chk("rst_alloc_valid", 32'(alloc_valid), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_commit_data", commit_data, 32'd0);
        chk("rst_commit_type", 32'(commit_type), 32'd0);
        chk("rst_overflow", 32'(overflow_err), 32'd0);

        // Basic allocate / writeback / commit.
        r_v = 1'b1; imm = 32'h5; exec_id = 4'd3;
        #1;
        chk("t1_alloc_valid", 32'(alloc_valid), 32'd1);
        chk("t1_alloc_tag", 32'(alloc_tag), 32'd0);
        tick();
        r_v = 1'b0; wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 32'hAB;
        #1;
        chk("t1_not_done_yet", 32'(commit_valid), 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t1_commit_valid", 32'(commit_valid), 32'd1);
        chk("t1_commit_type", 32'(commit_type), 32'b001);
        chk("t1_commit_data", commit_data, 32'hAB);
        chk("t1_commit_exec", 32'(commit_exec), 32'd3);
        chk("t1_commit_imm", commit_imm, 32'h5);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        #1;
        chk("t1_drained", 32'(commit_valid), 32'd0);

        // Fill with commit held off; the halted pipeline value must not be re-allocated.
        cnt_m = 0; acc_m = 1'b1; imm_n = 100;
        i_v = 1'b1; imm = 32'(imm_n); exec_id = 4'd1;
        for (int c = 0; c < 12; c++) begin
            exp_alloc = acc_m && (cnt_m < 8);
            exp_rdy   = (cnt_m <= 6);
            #1;
            chk("fill_alloc_valid", 32'(alloc_valid), 32'(exp_alloc));
            chk("fill_ready", 32'(rob_ready), 32'(exp_rdy));
            if (exp_alloc) chk("fill_alloc_tag", 32'(alloc_tag), 32'((1 + cnt_m) % 8));
            tick();
            if (exp_alloc) cnt_m++;
            acc_m = exp_rdy;
            if (exp_rdy) begin
                imm_n++;
                imm = 32'(imm_n);
            end
        end
        chk("fill_overflow", 32'(overflow_err), 32'd0);
        chk("fill_no_commit", 32'(commit_valid), 32'd0);

        // Flush the full buffer.
        i_v = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_full_ready", 32'(rob_ready), 32'd1);
        chk("flush_full_commit", 32'(commit_valid), 32'd0);

        // Out-of-order writeback, in-order commit.
        r_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imm = 32'(10 + k);
            #1;
            chk("ooo_alloc_tag", 32'(alloc_tag), 32'(k));
            tick();
        end
        r_v = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd2; wb_data = 32'h22;
        tick();
        chk("ooo_blocked_by_tag0", 32'(commit_valid), 32'd0);
        wb_tag = 3'd0; wb_data = 32'h20;
        tick();
        chk("ooo_c0_valid", 32'(commit_valid), 32'd1);
        chk("ooo_c0_tag", 32'(commit_tag), 32'd0);
        chk("ooo_c0_data", commit_data, 32'h20);
        wb_tag = 3'd1; wb_data = 32'h21; commit_ready = 1'b1;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("ooo_c1_tag", 32'(commit_tag), 32'd1);
        chk("ooo_c1_data", commit_data, 32'h21);
        tick();
        chk("ooo_c2_tag", 32'(commit_tag), 32'd2);
        chk("ooo_c2_data", commit_data, 32'h22);
        chk("ooo_c2_imm", commit_imm, 32'd12);
        tick();
        chk("ooo_empty", 32'(commit_valid), 32'd0);

        // Wrap-around: 20 instructions through a 2-deep steady state, head/tail start at 3.
        for (int k = 0; k < 22; k++) begin
            r_v = (k < 20);
            imm = 32'(k);
            wb_valid = (k >= 1) && (k <= 20);
            wb_tag = 3'((3 + k - 1) % 8);
            wb_data = 32'(256 + k - 1);
            #1;
            if (k < 20) chk("wrap_alloc_tag", 32'(alloc_tag), 32'((3 + k) % 8));
            if (k >= 2) begin
                chk("wrap_commit_valid", 32'(commit_valid), 32'd1);
                chk("wrap_commit_tag", 32'(commit_tag), 32'((3 + k - 2) % 8));
                chk("wrap_commit_imm", commit_imm, 32'(k - 2));
            end
            tick();
        end
        r_v = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0;
        #1;
        chk("wrap_empty_commit", 32'(commit_valid), 32'd0);
        chk("wrap_empty_ready", 32'(rob_ready), 32'd1);

        // Flush with 5 busy entries while alloc and writeback are active.
        r_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fl5_alloc_tag", 32'(alloc_tag), 32'((7 + k) % 8));
            tick();
        end
        wb_valid = 1'b1; wb_tag = 3'd7; wb_data = 32'h77; flush = 1'b1;
        tick();
        flush = 1'b0; r_v = 1'b0; wb_valid = 1'b0;
        #1;
        chk("fl5_commit_valid", 32'(commit_valid), 32'd0);
        chk("fl5_ready", 32'(rob_ready), 32'd1);
        r_v = 1'b1; imm = 32'h9;
        #1;
        chk("fl5_next_valid", 32'(alloc_valid), 32'd1);
        chk("fl5_next_tag", 32'(alloc_tag), 32'd0);
        tick();
        r_v = 1'b0; wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 32'h55;
        tick();
        wb_valid = 1'b0;
        #1;
        chk("fl5_after_commit", 32'(commit_valid), 32'd1);
        chk("fl5_after_data", commit_data, 32'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        // Overflow: hold accept_en high so an instruction arrives while full.
        force dut.accept_en_q = 1'b1;
        s_v = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("ovf_alloc_tag", 32'(alloc_tag), 32'(k));
            tick();
        end
        #1;
        chk("ovf_full_no_alloc", 32'(alloc_valid), 32'd0);
        chk("ovf_not_yet", 32'(overflow_err), 32'd0);
        tick();
        chk("ovf_set", 32'(overflow_err), 32'd1);
        s_v = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        release dut.accept_en_q;
        #1;
        chk("ovf_kept_by_flush", 32'(overflow_err), 32'd1);
        chk("ovf_flush_ready", 32'(rob_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("ovf_cleared_by_rst", 32'(overflow_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
